// File: rtl/wb_regfile_pkg.sv
// ============================================================================
// wb_regfile_pkg : shared bus widths, enable encodings and read-port helper
// Rev 1.0
// ============================================================================
`default_nettype none

package wb_regfile_pkg;

   localparam int RegBus     = 16;
   localparam int RegAddrBus = 4;
   localparam int RegNum     = 16;

   localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
   localparam logic [RegBus-1:0]     ZeroHalfWord = '0;
   localparam logic                  RstEnable    = 1'b1;
   localparam logic                  WriteEnable  = 1'b1;
   localparam logic                  WriteDisable = 1'b0;
   localparam logic                  ReadEnable   = 1'b1;
   localparam logic                  ReadDisable  = 1'b0;

   // A write to r0 is a discarded bubble: no storage, no bypass, no count.
   function automatic logic is_gpr_write(input logic                  wreg,
                                         input logic [RegAddrBus-1:0] wd);
      return (wreg == WriteEnable) && (wd != NOPRegAddr);
   endfunction

   function automatic logic [RegBus-1:0] gpr_read(
      input logic                  rst,
      input logic                  re,
      input logic [RegAddrBus-1:0] raddr,
      input logic                  wreg,
      input logic [RegAddrBus-1:0] wd,
      input logic [RegBus-1:0]     wdata,
      input logic [RegBus-1:0]     stored
   );
      logic [RegBus-1:0] result;
      result = stored;
      if (rst == RstEnable || re == ReadDisable || raddr == NOPRegAddr) begin
         result = ZeroHalfWord;
      end else if (is_gpr_write(wreg, wd) && raddr == wd) begin
         result = wdata;
      end
      return result;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wb_regfile_hilo_reg.sv
// ============================================================================
// hilo_reg : HI/LO register pair with same-cycle write-through bypass
// Rev 1.0
// ============================================================================
`default_nettype none

module hilo_reg
   import wb_regfile_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [RegBus-1:0] hi_i,
   input  logic [RegBus-1:0] lo_i,
   output logic [RegBus-1:0] hi_o,
   output logic [RegBus-1:0] lo_o
);

   logic [RegBus-1:0] hi_q, hi_d;
   logic [RegBus-1:0] lo_q, lo_d;

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (we == WriteEnable) begin
         hi_d = hi_i;
         lo_d = lo_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         hi_q <= ZeroHalfWord;
         lo_q <= ZeroHalfWord;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   always_comb begin
      hi_o = hi_q;
      lo_o = lo_q;
      if (rst == RstEnable) begin
         hi_o = ZeroHalfWord;
         lo_o = ZeroHalfWord;
      end else if (we == WriteEnable) begin
         hi_o = hi_i;
         lo_o = lo_i;
      end
   end

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
// ============================================================================
// wb_regfile : 16x16 GPR file with bypassed read ports, HI/LO and event counter
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_regfile
   import wb_regfile_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [RegAddrBus-1:0] wb_wd,
   input  logic                  wb_wreg,
   input  logic [RegBus-1:0]     wb_wdata,
   input  logic [RegBus-1:0]     wb_hi,
   input  logic [RegBus-1:0]     wb_lo,
   input  logic                  wb_whilo,
   input  logic                  re1,
   input  logic                  re2,
   input  logic [RegAddrBus-1:0] raddr1,
   input  logic [RegAddrBus-1:0] raddr2,
   output logic [RegBus-1:0]     rdata1,
   output logic [RegBus-1:0]     rdata2,
   output logic [RegBus-1:0]     hi_o,
   output logic [RegBus-1:0]     lo_o,
   output logic [RegBus-1:0]     wb_count
);

   logic [RegBus-1:0] gpr_q [RegNum];
   logic [RegBus-1:0] gpr_d [RegNum];
   logic [RegBus-1:0] wb_count_q, wb_count_d;
   logic              w_gpr_we;
   logic              w_event;

   assign w_gpr_we = is_gpr_write(wb_wreg, wb_wd);
   assign w_event  = w_gpr_we || (wb_whilo == WriteEnable);

   always_comb begin
      gpr_d = gpr_q;
      if (w_gpr_we) begin
         gpr_d[wb_wd] = wb_wdata;
      end
      gpr_d[0] = ZeroHalfWord;
   end

   always_comb begin
      wb_count_d = wb_count_q;
      if (w_event) begin
         wb_count_d = wb_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         for (int i = 0; i < RegNum; i++) begin
            gpr_q[i] <= ZeroHalfWord;
         end
         wb_count_q <= ZeroHalfWord;
      end else begin
         gpr_q      <= gpr_d;
         wb_count_q <= wb_count_d;
      end
   end

   always_comb begin
      rdata1 = gpr_read(rst, re1, raddr1, wb_wreg, wb_wd, wb_wdata, gpr_q[raddr1]);
      rdata2 = gpr_read(rst, re2, raddr2, wb_wreg, wb_wd, wb_wdata, gpr_q[raddr2]);
   end

   assign wb_count = wb_count_q;

   hilo_reg u_hilo_reg (
      .clk  (clk),
      .rst  (rst),
      .we   (wb_whilo),
      .hi_i (wb_hi),
      .lo_i (wb_lo),
      .hi_o (hi_o),
      .lo_o (lo_o)
   );

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// tb_wb_regfile : directed bench with a behavioural register-file model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  wb_wd;
   logic        wb_wreg;
   logic [15:0] wb_wdata;
   logic [15:0] wb_hi;
   logic [15:0] wb_lo;
   logic        wb_whilo;
   logic        re1, re2;
   logic [3:0]  raddr1, raddr2;
   logic [15:0] rdata1, rdata2, hi_o, lo_o, wb_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Architectural state as the rules describe it
   logic [15:0] m_gpr [16];
   logic [15:0] m_hi = 16'h0;
   logic [15:0] m_lo = 16'h0;
   logic [15:0] m_cnt = 16'h0;
   logic [15:0] cnt_before;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk      (clk),
      .rst      (rst),
      .wb_wd    (wb_wd),
      .wb_wreg  (wb_wreg),
      .wb_wdata (wb_wdata),
      .wb_hi    (wb_hi),
      .wb_lo    (wb_lo),
      .wb_whilo (wb_whilo),
      .re1      (re1),
      .re2      (re2),
      .raddr1   (raddr1),
      .raddr2   (raddr2),
      .rdata1   (rdata1),
      .rdata2   (rdata2),
      .hi_o     (hi_o),
      .lo_o     (lo_o),
      .wb_count (wb_count)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_read(input logic re, input logic [3:0] a);
      if (rst) return 16'h0;
      if (!re || a == 4'd0) return 16'h0;
      if (wb_wreg && wb_wd == a) return wb_wdata;
      return m_gpr[a];
   endfunction

   initial begin
      for (int i = 0; i < 16; i++) m_gpr[i] = 16'h0;
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) m_gpr[i] = 16'h0;
         m_hi = 16'h0; m_lo = 16'h0; m_cnt = 16'h0;
      end else begin
         if (wb_wreg && wb_wd != 4'd0) m_gpr[wb_wd] = wb_wdata;
         if (wb_whilo) begin m_hi = wb_hi; m_lo = wb_lo; end
         if ((wb_wreg && wb_wd != 4'd0) || wb_whilo) m_cnt = m_cnt + 16'd1;
      end
   end

   always @(negedge clk) begin
      check("mdl_rdata1", rdata1, exp_read(re1, raddr1));
      check("mdl_rdata2", rdata2, exp_read(re2, raddr2));
      check("mdl_hi", hi_o, rst ? 16'h0 : (wb_whilo ? wb_hi : m_hi));
      check("mdl_lo", lo_o, rst ? 16'h0 : (wb_whilo ? wb_lo : m_lo));
      check("mdl_count", wb_count, m_cnt);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_wreg = 1'b0; wb_whilo = 1'b0; wb_wd = 4'd0; wb_wdata = 16'h0;
      wb_hi = 16'h0; wb_lo = 16'h0;
   endtask

   task automatic at_sample();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; idle();
      re1 = 1'b1; re2 = 1'b1; raddr1 = 4'd0; raddr2 = 4'd0;
      step(); step();
      rst = 1'b0;

      // Reset then read every register
      for (int i = 1; i < 16; i++) begin
         raddr1 = 4'(i); raddr2 = 4'(i);
         at_sample();
         check("rst_rd1", rdata1, 16'h0);
         check("rst_rd2", rdata2, 16'h0);
         step();
      end
      check("rst_hi", hi_o, 16'h0);
      check("rst_lo", lo_o, 16'h0);
      check("rst_cnt", wb_count, 16'h0);

      // Write r5 then read it back
      wb_wreg = 1'b1; wb_wd = 4'd5; wb_wdata = 16'hA5A5; raddr1 = 4'd1;
      step();
      idle(); raddr1 = 4'd5;
      at_sample();
      check("wr_r5", rdata1, 16'hA5A5);
      check("wr_cnt", wb_count, 16'd1);
      step();

      // r0 is discarded and does not count
      wb_wreg = 1'b1; wb_wd = 4'd0; wb_wdata = 16'hFFFF; raddr1 = 4'd0;
      at_sample();
      check("r0_bypass", rdata1, 16'h0);
      step();
      idle();
      at_sample();
      check("r0_read", rdata1, 16'h0);
      check("r0_cnt", wb_count, 16'd1);
      step();

      // Bypass on both ports over a stale stored value
      wb_wreg = 1'b1; wb_wd = 4'd3; wb_wdata = 16'h1111;
      step();
      wb_wd = 4'd3; wb_wdata = 16'h2222; raddr1 = 4'd3; raddr2 = 4'd3;
      at_sample();
      check("byp_rd1", rdata1, 16'h2222);
      check("byp_rd2", rdata2, 16'h2222);
      re2 = 1'b0;
      #1;
      check("byp_re2_off", rdata2, 16'h0);
      check("byp_rd1_keep", rdata1, 16'h2222);
      step();
      idle(); re2 = 1'b1;

      // HI/LO with a simultaneous GPR write
      cnt_before = wb_count;
      wb_whilo = 1'b1; wb_hi = 16'h1234; wb_lo = 16'h5678;
      wb_wreg = 1'b1; wb_wd = 4'd7; wb_wdata = 16'h7777;
      at_sample();
      check("hilo_byp_hi", hi_o, 16'h1234);
      check("hilo_byp_lo", lo_o, 16'h5678);
      step();
      idle(); raddr1 = 4'd7;
      at_sample();
      check("hilo_hi", hi_o, 16'h1234);
      check("hilo_lo", lo_o, 16'h5678);
      check("hilo_r7", rdata1, 16'h7777);
      check("hilo_cnt", wb_count, cnt_before + 16'd1);
      step(); step();
      check("hilo_hi_persist", hi_o, 16'h1234);

      // Write during reset is ignored
      rst = 1'b1; wb_wreg = 1'b1; wb_wd = 4'd9; wb_wdata = 16'h00FF; raddr1 = 4'd9;
      at_sample();
      check("rst_mid_rd", rdata1, 16'h0);
      check("rst_mid_hi", hi_o, 16'h0);
      step();
      rst = 1'b0; idle();
      at_sample();
      check("rst_mid_r9", rdata1, 16'h0);
      check("rst_mid_cnt", wb_count, 16'h0);
      check("rst_mid_hi2", hi_o, 16'h0);
      step();

      // Counter wrap
      wb_wreg = 1'b1; wb_wd = 4'd1;
      for (int i = 0; i < 65535; i++) begin
         wb_wdata = 16'(i);
         step();
      end
      idle();
      check("cnt_full", wb_count, 16'hFFFF);
      wb_whilo = 1'b1; wb_hi = 16'hBEEF; wb_lo = 16'hCAFE;
      step();
      idle();
      check("cnt_wrap", wb_count, 16'h0000);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports are named clk and rst.
REQ-002 clk  input  1  rising-edge clock shared with the pipeline.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 wb_wd  input  4  destination GPR address from the writeback stage register.
REQ-005 wb_wreg  input  1  GPR write enable from the writeback stage register.
REQ-006 wb_wdata  input  16  GPR write data.
REQ-007 wb_hi, wb_lo  input  16 each  HI/LO write data.
REQ-008 wb_whilo  input  1  HI/LO write enable.
REQ-009 re1, re2  input  1 each  read-port enables, driven from decode.
REQ-010 raddr1, raddr2  input  4 each  read-port addresses.
REQ-011 rdata1, rdata2  output  16 each  read data, combinational.
REQ-012 hi_o, lo_o  output  16 each  current HI/LO value, forwarded.
REQ-013 wb_count  output  16  count of retired writeback events, for debug.

Function
REQ-014 Sixteen 16-bit GPRs; r0 is hardwired to 0x0000 and is never written.
REQ-015 GPR write occurs at the rising edge when rst=0, wb_wreg=1 and wb_wd!=0; the value is visible in storage the next cycle.
REQ-016 rdataN is 0x0000 in any of these cases: rst=1, reN=0, or raddrN=0.
REQ-017 When rst=0, reN=1, raddrN!=0, wb_wreg=1 and raddrN==wb_wd, rdataN is wb_wdata in the same cycle (write-through bypass, 0 extra cycles).
REQ-018 In all other cases rdataN is the stored GPR[raddrN].
REQ-019 Both read ports are independent; reading the same address on both ports returns identical data.
REQ-020 HI/LO are written together at the rising edge when rst=0 and wb_whilo=1.
REQ-021 hi_o/lo_o track HI/LO as follows:
- 0x0000 when rst=1;
- wb_hi/wb_lo when wb_whilo=1 (same-cycle bypass);
- otherwise the stored HI/LO.
REQ-022 A simultaneous GPR write and HI/LO write in one cycle both take effect.
REQ-023 wb_count increments by 1 at each rising edge where rst=0 and the cycle is a writeback event:
- (wb_wreg=1 and wb_wd!=0), or wb_whilo=1;
- such a cycle counts once even if both writes occur.
REQ-024 wb_count wraps from 0xFFFF to 0x0000.
REQ-025 The block never stalls; the stall vector does not enter it, so any bubble arrives as wb_wreg=0 and wb_whilo=0.
REQ-026 A write with wb_wreg=1 and wb_wd=0 is discarded, does not bypass, and does not count.

Reset
REQ-027 On a rising edge with rst=1, all GPRs, HI, LO and wb_count are cleared to 0x0000.
REQ-028 Write inputs present during a reset cycle are ignored, including when reset is asserted in the middle of an instruction stream.
REQ-029 The first write accepted after reset is the one present in the first cycle with rst=0.

Structure
REQ-030 RegBus (16), RegAddrBus (4), RegNum (16), NOPRegAddr, ZeroHalfWord, RstEnable, WriteEnable/WriteDisable, ReadEnable/ReadDisable SHALL come from the shared define.v; no local literals are used for these.
REQ-031 The HI/LO storage and its bypass SHALL be a sub-module named hilo_reg; the GPR array, read ports and counter stay at top level.

Verification
REQ-032 Reset then read: assert rst for 2 cycles, then read r1..r15 on both ports -> all 0x0000; hi_o=lo_o=wb_count=0x0000.
REQ-033 Write then read:
- write r5=0xA5A5;
- next cycle read raddr1=5 -> 0xA5A5;
- write r0=0xFFFF -> read r0 = 0x0000 and wb_count unchanged.
REQ-034 Bypass:
- r3 holds 0x1111;
- in the same cycle drive wb_wreg=1, wb_wd=3, wb_wdata=0x2222 with raddr1=raddr2=3 -> both ports show 0x2222;
- with re2=0 instead, rdata2 = 0x0000.
REQ-035 HI/LO:
- wb_whilo=1, wb_hi=0x1234, wb_lo=0x5678 together with a write of r7 -> same-cycle hi_o/lo_o = 0x1234/0x5678;
- both values persist afterwards;
- wb_count increases by exactly 1.
REQ-036 Reset mid-stream:
- write r9=0x00FF while rst=1 -> r9 reads 0x0000 after reset;
- preload wb_count=0xFFFF via writes, then one more event -> wb_count = 0x0000.
